// File: rtl/slave_rx_port.sv
// slave_rx_port: slave-side responder of the serial system bus.
// Decodes a bit-serial header (address, burst count), then either
// collects serial write words into local memory or streams memory
// words back serially to the master.
//
// Optional feature macro: SLAVE_RX_TIMEOUT_EN
//   defined   -> RX_DATA aborts with an error pulse once master_valid has
//                been low for more than TIMEOUT consecutive cycles
//   undefined -> RX_DATA waits indefinitely, error tied low
//
// state    | meaning
// ---------+---------------------------------------------------------
// IDLE     | waiting for select match plus write_en/read_en
// RX_HDR   | sampling ADDR_LEN address bits (and BURST_LEN burst bits)
// RX_DATA  | shifting in write data on master_valid, writing words
// RD_FETCH | one cycle to load the read shift register from memory
// TX_DATA  | driving read data LSB first, burst+1 words back-to-back

module slave_rx_port #(
   parameter int SLAVE_LEN    = 2,
   parameter int SLAVE_ID     = 0,
   parameter int ADDR_LEN     = 12,
   parameter int DATA_LEN     = 8,
   parameter int BURST_LEN    = 12,
   parameter int MEM_ADDR_LEN = 6,
   parameter int TIMEOUT      = 10
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [SLAVE_LEN-1:0] slave_select,
   input  logic                 write_en,
   input  logic                 read_en,
   input  logic                 tx_address,
   input  logic                 tx_burst_number,
   input  logic                 master_valid,
   input  logic                 tx_data,
   output logic                 slave_ready,
   output logic                 slave_valid,
   output logic                 slave_tx_data,
   output logic                 write_done,
   output logic                 read_done,
   output logic                 error
);

   localparam int HDR_W = (ADDR_LEN > 1) ? $clog2(ADDR_LEN) : 1;
   localparam int BIT_W = (DATA_LEN > 1) ? $clog2(DATA_LEN) : 1;
   localparam int DEPTH = 2 ** MEM_ADDR_LEN;
   localparam logic [HDR_W-1:0] HDR_LAST = HDR_W'(ADDR_LEN - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_LEN - 1);

   if (BURST_LEN > ADDR_LEN || MEM_ADDR_LEN > ADDR_LEN || TIMEOUT < 0) begin : g_bad_cfg
      $error("slave_rx_port: BURST_LEN and MEM_ADDR_LEN must not exceed ADDR_LEN");
   end

   typedef enum logic [2:0] {IDLE, RX_HDR, RX_DATA, RD_FETCH, TX_DATA} state_t;

   state_t                  state_q, state_d;
   logic [HDR_W-1:0]        hdr_cnt;
   logic [BIT_W-1:0]        bit_cnt;
   logic [BURST_LEN:0]      word_cnt;
   logic [BURST_LEN-1:0]    burst_q;
   logic [MEM_ADDR_LEN-1:0] waddr;
   logic [MEM_ADDR_LEN-1:0] waddr_inc;
   logic                    is_wr;
   logic [DATA_LEN-1:0]     wshift;
   logic [DATA_LEN-1:0]     rshift;
   logic [DATA_LEN-1:0]     mem [DEPTH];

   logic start, hdr_last, bit_last, word_last, wr_fin, rd_fin;

   assign start     = (slave_select == SLAVE_LEN'(SLAVE_ID)) && (write_en || read_en);
   assign hdr_last  = (hdr_cnt == HDR_LAST);
   assign bit_last  = (bit_cnt == BIT_LAST);
   assign word_last = (word_cnt == {1'b0, burst_q});
   assign waddr_inc = waddr + 1'b1;

`ifdef SLAVE_RX_TIMEOUT_EN
   localparam int IDLE_W = $clog2(TIMEOUT + 2);
   logic [IDLE_W-1:0] idle_cnt;
   logic              to_fin;
`endif

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next-state decode and level outputs
   always_comb begin
      state_d       = state_q;
      slave_ready   = 1'b0;
      slave_valid   = 1'b0;
      slave_tx_data = 1'b0;
      wr_fin        = 1'b0;
      rd_fin        = 1'b0;
`ifdef SLAVE_RX_TIMEOUT_EN
      to_fin        = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            slave_ready = 1'b1;
            if (start) state_d = RX_HDR;
         end
         RX_HDR: begin
            slave_ready = 1'b1;
            if (hdr_last) state_d = is_wr ? RX_DATA : RD_FETCH;
         end
         RX_DATA: begin
            slave_ready = 1'b1;
            if (master_valid && bit_last && word_last) begin
               state_d = IDLE;
               wr_fin  = 1'b1;
            end
`ifdef SLAVE_RX_TIMEOUT_EN
            else if (!master_valid && idle_cnt == IDLE_W'(TIMEOUT)) begin
               state_d = IDLE;
               to_fin  = 1'b1;
            end
`endif
         end
         RD_FETCH: begin
            state_d = TX_DATA;
         end
         TX_DATA: begin
            slave_valid   = 1'b1;
            slave_tx_data = rshift[0];
            if (bit_last && word_last) begin
               state_d = IDLE;
               rd_fin  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Counters, header capture, shift registers and done pulses
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hdr_cnt    <= '0;
         bit_cnt    <= '0;
         word_cnt   <= '0;
         burst_q    <= '0;
         waddr      <= '0;
         is_wr      <= 1'b0;
         wshift     <= '0;
         rshift     <= '0;
         write_done <= 1'b0;
         read_done  <= 1'b0;
      end else begin
         write_done <= wr_fin;
         read_done  <= rd_fin;
         case (state_q)
            IDLE: begin
               if (start) begin
                  is_wr    <= write_en;
                  hdr_cnt  <= '0;
                  bit_cnt  <= '0;
                  word_cnt <= '0;
                  burst_q  <= '0;
                  waddr    <= '0;
               end
            end
            RX_HDR: begin
               hdr_cnt <= hdr_cnt + 1'b1;
               // only the low address bits index memory; upper bits are dropped
               if (int'(hdr_cnt) < MEM_ADDR_LEN)
                  waddr <= {tx_address, waddr[MEM_ADDR_LEN-1:1]};
               if (int'(hdr_cnt) < BURST_LEN)
                  burst_q <= {tx_burst_number, burst_q[BURST_LEN-1:1]};
            end
            RX_DATA: begin
               if (master_valid) begin
                  wshift <= {tx_data, wshift[DATA_LEN-1:1]};
                  if (bit_last) begin
                     bit_cnt  <= '0;
                     word_cnt <= word_cnt + 1'b1;
                     waddr    <= waddr_inc;
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end
            end
            RD_FETCH: begin
               rshift  <= mem[waddr];
               bit_cnt <= '0;
            end
            TX_DATA: begin
               if (bit_last) begin
                  bit_cnt  <= '0;
                  word_cnt <= word_cnt + 1'b1;
                  waddr    <= waddr_inc;
                  rshift   <= mem[waddr_inc];
               end else begin
                  bit_cnt <= bit_cnt + 1'b1;
                  rshift  <= {1'b0, rshift[DATA_LEN-1:1]};
               end
            end
            default: ;
         endcase
      end
   end

   // Word write on the final bit of each received word; memory keeps contents across reset
   always_ff @(posedge clk) begin
      if (state_q == RX_DATA && master_valid && bit_last)
         mem[waddr] <= {tx_data, wshift[DATA_LEN-1:1]};
   end

`ifdef SLAVE_RX_TIMEOUT_EN
   // Consecutive idle-cycle counter for write-data timeout and error pulse
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         idle_cnt <= '0;
         error    <= 1'b0;
      end else begin
         error <= to_fin;
         if (state_q != RX_DATA || master_valid) idle_cnt <= '0;
         else                                    idle_cnt <= idle_cnt + 1'b1;
      end
   end
`else
   assign error = 1'b0;
`endif

endmodule

// File: tb/tb_slave_rx_port.sv
// Bench for slave_rx_port: table of write/read frames plus hand-written
// reset-mid-read and write-data timeout sequences. Read data is checked
// against a queue of expected words pushed when each read frame starts.

module tb_slave_rx_port;

   localparam int SLAVE_LEN    = 2;
   localparam int SLAVE_ID     = 1;
   localparam int ADDR_LEN     = 12;
   localparam int DATA_LEN     = 8;
   localparam int BURST_LEN    = 12;
   localparam int MEM_ADDR_LEN = 6;
   localparam int TIMEOUT      = 10;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [1:0] slave_select = '0;
   logic       write_en = 1'b0, read_en = 1'b0;
   logic       tx_address = 1'b0, tx_burst_number = 1'b0;
   logic       master_valid = 1'b0, tx_data = 1'b0;
   logic       slave_ready, slave_valid, slave_tx_data;
   logic       write_done, read_done, error;

   always #5 clk = ~clk;

   slave_rx_port #(
      .SLAVE_LEN(SLAVE_LEN), .SLAVE_ID(SLAVE_ID), .ADDR_LEN(ADDR_LEN),
      .DATA_LEN(DATA_LEN), .BURST_LEN(BURST_LEN),
      .MEM_ADDR_LEN(MEM_ADDR_LEN), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk), .reset(reset), .slave_select(slave_select),
      .write_en(write_en), .read_en(read_en), .tx_address(tx_address),
      .tx_burst_number(tx_burst_number), .master_valid(master_valid),
      .tx_data(tx_data), .slave_ready(slave_ready), .slave_valid(slave_valid),
      .slave_tx_data(slave_tx_data), .write_done(write_done),
      .read_done(read_done), .error(error)
   );

   typedef struct {
      logic        is_wr;
      logic        both;
      logic        bad_sel;
      logic [11:0] addr;
      logic [11:0] burst;
      logic [2:0][7:0] d;
      int          gap_at;
   } vec_t;

   vec_t        tab [13];
   int          n_checks = 0;
   int          n_pass = 0;
   logic [7:0]  sb_q [$];
   logic [7:0]  tw;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, want %0h", name, act, exp);
   endtask

   task automatic start_frame(input logic [1:0] sel, input logic wr, input logic rd);
      slave_select = sel;
      write_en     = wr;
      read_en      = rd;
      @(negedge clk);
      write_en     = 1'b0;
      read_en      = 1'b0;
      slave_select = 2'd0;
   endtask

   task automatic send_header(input logic [11:0] addr, input logic [11:0] burst);
      for (int i = 0; i < ADDR_LEN; i++) begin
         tx_address      = addr[i];
         tx_burst_number = burst[i];
         @(negedge clk);
      end
      tx_address      = 1'b0;
      tx_burst_number = 1'b0;
   endtask

   task automatic send_bit(input logic b);
      master_valid = 1'b1;
      tx_data      = b;
      @(negedge clk);
      master_valid = 1'b0;
      tx_data      = 1'b0;
   endtask

   task automatic do_write(input vec_t v, input string tag);
      logic [1:0] sel;
      int         nw;
      sel = v.bad_sel ? 2'd2 : 2'd1;
      nw  = int'(v.burst) + 1;
      start_frame(sel, 1'b1, v.both);
      send_header(v.addr, v.burst);
      for (int k = 0; k < nw; k++) begin
         for (int j = 0; j < DATA_LEN; j++) begin
            if (k == 0 && j == v.gap_at) begin
               repeat (3) begin
                  master_valid = 1'b0;
                  tx_data      = ~v.d[k][j];
                  @(negedge clk);
               end
            end
            if (k == nw - 1 && j == DATA_LEN - 1)
               check({tag, " done_early"}, write_done, 0);
            send_bit(v.d[k][j]);
         end
      end
      check({tag, " write_done"}, write_done, v.bad_sel ? 0 : 1);
      @(negedge clk);
      check({tag, " done_pulse"}, write_done, 0);
   endtask

   task automatic do_read(input vec_t v, input string tag);
      int         nw;
      int         bad_valid;
      logic [7:0] word;
      logic [7:0] exp_w;
      nw        = int'(v.burst) + 1;
      bad_valid = 0;
      word      = '0;
      start_frame(2'd1, 1'b0, 1'b1);
      send_header(v.addr, v.burst);
      check({tag, " fetch_vr"}, {slave_valid, slave_ready}, 2'b00);
      for (int k = 0; k < nw; k++) sb_q.push_back(v.d[k]);
      @(negedge clk);
      for (int c = 0; c < nw * DATA_LEN; c++) begin
         if (slave_valid !== 1'b1) bad_valid++;
         word[c % DATA_LEN] = slave_tx_data;
         if (c % DATA_LEN == DATA_LEN - 1) begin
            if (sb_q.size() == 0) begin
               check({tag, " sb_empty"}, sb_q.size(), 1);
            end else begin
               exp_w = sb_q.pop_front();
               check({tag, " rd_word"}, word, exp_w);
            end
         end
         @(negedge clk);
      end
      check({tag, " valid_window"}, bad_valid, 0);
      check({tag, " end_v_done_d"}, {slave_valid, read_done, slave_tx_data}, 3'b010);
      @(negedge clk);
      check({tag, " rd_pulse"}, read_done, 0);
      check({tag, " sb_drained"}, sb_q.size(), 0);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      //           wr   both bad  addr     burst    data(d2,d1,d0)  gap
      tab[0]  = '{1'b1, 1'b0, 1'b0, 12'h005, 12'h000, 24'h0000A5, -1};
      tab[1]  = '{1'b1, 1'b0, 1'b0, 12'h03F, 12'h002, 24'h332211, -1};
      tab[2]  = '{1'b0, 1'b0, 1'b0, 12'h03F, 12'h001, 24'h002211, -1};
      tab[3]  = '{1'b0, 1'b0, 1'b0, 12'h005, 12'h000, 24'h0000A5, -1};
      tab[4]  = '{1'b0, 1'b0, 1'b0, 12'h000, 12'h001, 24'h003322, -1};
      tab[5]  = '{1'b1, 1'b0, 1'b0, 12'hFC1, 12'h000, 24'h00005C,  3};
      tab[6]  = '{1'b0, 1'b0, 1'b0, 12'h001, 12'h000, 24'h00005C, -1};
      tab[7]  = '{1'b1, 1'b0, 1'b1, 12'h005, 12'h000, 24'h0000FF, -1};
      tab[8]  = '{1'b0, 1'b0, 1'b0, 12'h005, 12'h000, 24'h0000A5, -1};
      tab[9]  = '{1'b1, 1'b1, 1'b0, 12'h002, 12'h000, 24'h00003C, -1};
      tab[10] = '{1'b0, 1'b0, 1'b0, 12'h002, 12'h000, 24'h00003C, -1};
      tab[11] = '{1'b0, 1'b0, 1'b0, 12'h03F, 12'h002, 24'h5C2211, -1};
      tab[12] = '{1'b0, 1'b0, 1'b0, 12'hF3F, 12'h000, 24'h000011, -1};

      repeat (3) @(negedge clk);
      check("reset_outputs",
            {slave_ready, slave_valid, slave_tx_data, write_done, read_done, error},
            6'b100000);
      reset = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 13; i++) begin
         if (tab[i].is_wr) do_write(tab[i], $sformatf("v%0d", i));
         else              do_read(tab[i], $sformatf("v%0d", i));
      end

      // reset asserted in the middle of a read stream
      start_frame(2'd1, 1'b0, 1'b1);
      send_header(12'h03F, 12'h001);
      @(negedge clk);
      @(negedge clk);
      check("rst_pre_valid", slave_valid, 1);
      #2 reset = 1'b0;
      #1 check("rst_async_vrd", {slave_valid, slave_ready, slave_tx_data}, 3'b010);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      do_read('{1'b0, 1'b0, 1'b0, 12'h03F, 12'h000, 24'h000011, -1}, "post_rst");

`ifdef SLAVE_RX_TIMEOUT_EN
      // master_valid stalls for 11 cycles after 4 bits: abort, mem[5] untouched
      start_frame(2'd1, 1'b1, 1'b0);
      send_header(12'h005, 12'h000);
      for (int j = 0; j < 4; j++) send_bit(1'b0);
      master_valid = 1'b0;
      repeat (10) @(negedge clk);
      check("to_no_early", error, 0);
      @(negedge clk);
      check("to_error", error, 1);
      @(negedge clk);
      check("to_pulse", error, 0);
      check("to_no_wdone", write_done, 0);
      do_read('{1'b0, 1'b0, 1'b0, 12'h005, 12'h000, 24'h0000A5, -1}, "to_rb");
`else
      // without the timeout the same stall is simply waited out
      tw = 8'h96;
      start_frame(2'd1, 1'b1, 1'b0);
      send_header(12'h007, 12'h000);
      for (int j = 0; j < 4; j++) send_bit(tw[j]);
      master_valid = 1'b0;
      repeat (11) @(negedge clk);
      check("stall_no_error", error, 0);
      @(negedge clk);
      check("stall_no_error2", error, 0);
      for (int j = 4; j < DATA_LEN; j++) send_bit(tw[j]);
      check("stall_wdone", write_done, 1);
      @(negedge clk);
      do_read('{1'b0, 1'b0, 1'b0, 12'h007, 12'h000, 24'h000096, -1}, "stall_rb");
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
